// File: rtl/fifo_pack_pkg.sv
// Shared types, defaults and helpers for the packing FIFO.
package fifo_pack_pkg;

    localparam int unsigned DEF_DIN_W     = 32;
    localparam int unsigned DEF_RATIO     = 8;
    localparam int unsigned DEF_DEPTH     = 128;
    localparam int unsigned DEF_AE_THRESH = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_pack_ram.sv
// Simple dual-port word store; read port is registered unless FIFO_PACK_FWFT_EN
// selects a combinational read for first-word-fall-through.
module fifo_pack_ram
    import fifo_pack_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned DEPTH = 128,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef FIFO_PACK_FWFT_EN
    logic fwft_unused;

    assign rdata       = mem_q[raddr];
    assign fwft_unused = re ^ rst_n;
`else
    logic [DW-1:0] rdata_q, rdata_d;

    // Holds the last popped word until the next pop.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_pack_sync.sv
// Width-converting FIFO: packs RATIO narrow beats per wide word, DEPTH words deep.
// Define FIFO_PACK_FWFT_EN for first-word-fall-through reads.
module fifo_pack_sync
    import fifo_pack_pkg::*;
#(
    parameter int unsigned DIN_W     = DEF_DIN_W,
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH,
    localparam int unsigned DOUT_W   = DIN_W * RATIO,
    localparam int unsigned RC_W     = clog2(DEPTH) + 1,
    localparam int unsigned WC_W     = clog2(DEPTH * RATIO) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  din,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DOUT_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [WC_W-1:0]   wr_count,
    output logic [RC_W-1:0]   rd_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = clog2(RATIO);

    logic [RATIO-1:0][DIN_W-1:0] pack_q, pack_d;
    logic [PW-1:0]               pack_cnt_q, pack_cnt_d;
    logic [AW-1:0]               wptr_q, wptr_d;
    logic [AW-1:0]               rptr_q, rptr_d;
    logic [RC_W-1:0]             occ_q, occ_d;
    fifo_status_t                stat_q, stat_d;

    logic                        wr_acc;
    logic                        commit;
    logic                        pop;
    logic [DOUT_W-1:0]           commit_word;
    logic [DOUT_W-1:0]           ram_rdata;

    // Full/empty come from the registered status, so strobes never reach them combinationally.
    always_comb begin
        wr_acc      = wr_en && !stat_q.full;
        commit      = wr_acc && (pack_cnt_q == PW'(RATIO - 1));
        pop         = rd_en && !stat_q.empty;
        commit_word = {din, pack_q[RATIO-2:0]};

        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        if (wr_acc) begin
            pack_d[pack_cnt_q] = din;
            pack_cnt_d         = pack_cnt_q + PW'(1);
        end

        wptr_d = commit ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        occ_d  = occ_q + RC_W'(commit) - RC_W'(pop);

        stat_d              = stat_q;
        stat_d.full         = (occ_d == RC_W'(DEPTH));
        stat_d.empty        = (occ_d == '0);
        stat_d.almost_full  = (occ_d >= RC_W'(AF_THRESH));
        stat_d.almost_empty = (occ_d <= RC_W'(AE_THRESH));
        stat_d.overflow     = (wr_en && stat_q.full) || (stat_q.overflow && !clr_err);
        stat_d.underflow    = (rd_en && stat_q.empty) || (stat_q.underflow && !clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q     <= '0;
            pack_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            stat_q     <= STATUS_RST;
        end else begin
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            stat_q     <= stat_d;
        end
    end

    fifo_pack_ram #(
        .DW    (DOUT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (wptr_q),
        .wdata (commit_word),
        .re    (pop),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

`ifdef FIFO_PACK_FWFT_EN
    assign valid = !stat_q.empty;
    assign dout  = stat_q.empty ? '0 : ram_rdata;
`else
    logic valid_q, valid_d;

    always_comb begin
        valid_d = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign dout  = ram_rdata;
`endif

    // Occupancy times a power-of-two ratio plus the partial count is a plain concatenation.
    assign wr_count     = WC_W'({occ_q, pack_cnt_q});
    assign rd_count     = occ_q;
    assign full         = stat_q.full;
    assign empty        = stat_q.empty;
    assign almost_full  = stat_q.almost_full;
    assign almost_empty = stat_q.almost_empty;
    assign overflow     = stat_q.overflow;
    assign underflow    = stat_q.underflow;

endmodule

// File: tb/tb_fifo_pack_sync.sv
// Directed bench for fifo_pack_sync at DIN_W=32, RATIO=4, DEPTH=4, AF=3, AE=1.
module tb_fifo_pack_sync;

    logic         clk;
    logic         rst_n;
    logic [31:0]  din;
    logic         wr_en;
    logic         rd_en;
    logic         clr_err;
    logic [127:0] dout;
    logic         valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [4:0]   wr_count;
    logic [2:0]   rd_count;
    logic         overflow;
    logic         underflow;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_pack_sync #(
        .DIN_W     (32),
        .RATIO     (4),
        .DEPTH     (4),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .dout         (dout),
        .valid        (valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_count     (wr_count),
        .rd_count     (rd_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] w4(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d);
        din   = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] b);
        for (int i = 0; i < 4; i++) put(b + 32'(i));
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, 128'(empty), 128'd1);
        check({tag, "_full"}, 128'(full), 128'd0);
        check({tag, "_ae"}, 128'(almost_empty), 128'd1);
        check({tag, "_af"}, 128'(almost_full), 128'd0);
        check({tag, "_valid"}, 128'(valid), 128'd0);
        check({tag, "_dout"}, dout, 128'd0);
        check({tag, "_wrcnt"}, 128'(wr_count), 128'd0);
        check({tag, "_rdcnt"}, 128'(rd_count), 128'd0);
        check({tag, "_ovf"}, 128'(overflow), 128'd0);
        check({tag, "_unf"}, 128'(underflow), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        din     = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        pop1();
        check("unf_set", 128'(underflow), 128'd1);
        check("unf_valid", 128'(valid), 128'd0);
        check("unf_dout", dout, 128'd0);
        clear_err();
        check("unf_clr", 128'(underflow), 128'd0);

`ifndef FIFO_PACK_FWFT_EN
        put(32'h0);
        put(32'h1);
        put(32'h2);
        check("part_wrcnt", 128'(wr_count), 128'd3);
        check("part_empty", 128'(empty), 128'd1);
        put(32'h3);
        check("w1_empty", 128'(empty), 128'd0);
        check("w1_rdcnt", 128'(rd_count), 128'd1);
        check("w1_wrcnt", 128'(wr_count), 128'd4);
        check("w1_valid_pre", 128'(valid), 128'd0);
        pop1();
        check("pop1_valid", 128'(valid), 128'd1);
        check("pop1_dout", dout, 128'h00000003_00000002_00000001_00000000);
        check("pop1_empty", 128'(empty), 128'd1);
        step();
        check("pop1_valid_drop", 128'(valid), 128'd0);
        check("pop1_dout_hold", dout, w4(32'h0));

        for (int i = 0; i < 16; i++) begin
            put(32'h10 + 32'(i));
            if (i == 7) begin
                check("half_rdcnt", 128'(rd_count), 128'd2);
                check("half_af", 128'(almost_full), 128'd0);
                check("half_ae", 128'(almost_empty), 128'd0);
            end
        end
        check("fill_full", 128'(full), 128'd1);
        check("fill_af", 128'(almost_full), 128'd1);
        check("fill_wrcnt", 128'(wr_count), 128'd16);
        put(32'hdead);
        check("ovf_set", 128'(overflow), 128'd1);
        check("ovf_wrcnt", 128'(wr_count), 128'd16);
        clear_err();
        check("ovf_clr", 128'(overflow), 128'd0);
        din     = 32'hdead;
        wr_en   = 1'b1;
        clr_err = 1'b1;
        step();
        wr_en   = 1'b0;
        clr_err = 1'b0;
        check("ovf_clr_race", 128'(overflow), 128'd1);

        din   = 32'hbeef;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("drop_ovf", 128'(overflow), 128'd1);
        check("drop_rdcnt", 128'(rd_count), 128'd3);
        check("drop_wrcnt", 128'(wr_count), 128'd12);
        check("drop_full", 128'(full), 128'd0);
        check("drop_af", 128'(almost_full), 128'd1);
        check("drop_dout", dout, w4(32'h10));

        rd_en = 1'b1;
        step();
        check("drain0", dout, w4(32'h14));
        step();
        check("drain1", dout, w4(32'h18));
        step();
        rd_en = 1'b0;
        check("drain2", dout, w4(32'h1c));
        check("drain_valid", 128'(valid), 128'd1);
        check("drain_empty", 128'(empty), 128'd1);
        clear_err();

        put(32'h30);
        put(32'h31);
        put(32'h32);
        din   = 32'h33;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("cie_unf", 128'(underflow), 128'd1);
        check("cie_valid", 128'(valid), 128'd0);
        check("cie_rdcnt", 128'(rd_count), 128'd1);
        pop1();
        check("cie_dout", dout, w4(32'h30));
        clear_err();

        put_word(32'h40);
        put(32'h50);
        put(32'h51);
        put(32'h52);
        din   = 32'h53;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("cp_rdcnt", 128'(rd_count), 128'd1);
        check("cp_dout", dout, w4(32'h40));
        check("cp_unf", 128'(underflow), 128'd0);
        pop1();
        check("cp_dout2", dout, w4(32'h50));
        check("cp_empty", 128'(empty), 128'd1);

        put(32'h60);
        put(32'h61);
        check("arst_pre_wrcnt", 128'(wr_count), 128'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        #2;
        rst_n = 1'b1;
        put_word(32'h70);
        check("fresh_wrcnt", 128'(wr_count), 128'd4);
        pop1();
        check("fresh_dout", dout, w4(32'h70));
`else
        put_word(32'h0);
        check("fw_valid", 128'(valid), 128'd1);
        check("fw_dout", dout, w4(32'h0));
        check("fw_empty", 128'(empty), 128'd0);
        put_word(32'h10);
        check("fw_head_hold", dout, w4(32'h0));
        check("fw_rdcnt", 128'(rd_count), 128'd2);
        pop1();
        check("fw_next_valid", 128'(valid), 128'd1);
        check("fw_next_dout", dout, w4(32'h10));
        pop1();
        check("fw_drain_valid", 128'(valid), 128'd0);
        check("fw_drain_empty", 128'(empty), 128'd1);

        for (int i = 0; i < 4; i++) put_word(32'h20 + 32'(4 * i));
        check("fw_full", 128'(full), 128'd1);
        check("fw_full_wrcnt", 128'(wr_count), 128'd16);
        check("fw_full_head", dout, w4(32'h20));
        din   = 32'hbeef;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("fw_drop_ovf", 128'(overflow), 128'd1);
        check("fw_drop_rdcnt", 128'(rd_count), 128'd3);
        check("fw_drop_head", dout, w4(32'h24));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
